// File: rtl/qspi_pkg.sv
// qspi_pkg
//   Definitions shared by the QSPI initiator and the QSPI memory responder:
//   the supported opcodes, the address phase length and the responder state
//   encoding. No ports (package).
package qspi_pkg;

  localparam logic [7:0] CMD_QREAD  = 8'hEB;
  localparam logic [7:0] CMD_QWRITE = 8'h38;

  // 24-bit address sent as six quad nibbles, high nibble first
  localparam int ADDR_NIBBLES = 6;

  // Plain vector encoding so older tools and the initiator can share it
  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_CMD    = 3'd1;
  localparam state_t ST_ADDR   = 3'd2;
  localparam state_t ST_DUMMY  = 3'd3;
  localparam state_t ST_RDATA  = 3'd4;
  localparam state_t ST_WDATA  = 3'd5;
  localparam state_t ST_IGNORE = 3'd6;

endpackage

// File: rtl/qspi_sync_edge.sv
// qspi_sync_edge
//   Multi-flop synchronizer for one asynchronous input with rise/fall
//   detection on the synchronized signal.
// Ports:
//   clk   in   system clock
//   rst   in   asynchronous active-high reset
//   d     in   asynchronous input
//   rise  out  one clk pulse when the synchronized input goes 0 -> 1
//   fall  out  one clk pulse when the synchronized input goes 1 -> 0
module qspi_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign fall = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/qspi_mem_responder.sv
// qspi_mem_responder
//   QSPI memory model for bring-up builds and CPU-level simulation. Serves
//   quad read (0xEB) and quad write (0x38) from an internal byte array that
//   can be preloaded through a backdoor port. sclk, cs_n and io are
//   oversampled with clk, which must run at least 8x sclk.
// Ports:
//   clk, rst        system clock, asynchronous active-high reset
//   sclk, cs_n      QSPI clock and chip select from the initiator
//   io_in           QSPI data lines from the pads
//   io_out, io_oe   QSPI data driven back, per-line output enable
//   bd_we, bd_addr, bd_wdata, bd_rdata   backdoor memory access
//   active          transaction in progress
//   cmd_err         sticky unsupported-opcode flag
//
// state     | meaning
// ----------+------------------------------------------------------
// IDLE      | cs_n high, waiting for select
// CMD       | shifting in 8 opcode bits on io[0]
// ADDR      | shifting in 6 address nibbles
// DUMMY     | counting dummy sclk edges before read data
// RDATA     | driving read nibbles on sclk falling edges
// WDATA     | capturing write nibbles on sclk rising edges
// IGNORE    | unsupported opcode, silent until deselect
module qspi_mem_responder
  import qspi_pkg::*;
#(
  parameter int ADDR_W       = 8,
  parameter int DUMMY_CYCLES = 6,
  parameter int SYNC_STAGES  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic [3:0]        io_in,
  output logic [3:0]        io_out,
  output logic [3:0]        io_oe,
  input  logic              bd_we,
  input  logic [ADDR_W-1:0] bd_addr,
  input  logic [7:0]        bd_wdata,
  output logic [7:0]        bd_rdata,
  output logic              active,
  output logic              cmd_err
);

  localparam int DEPTH = 1 << ADDR_W;

  logic sclk_rise, sclk_fall;

  qspi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_sync (
    .clk  (clk),
    .rst  (rst),
    .d    (sclk),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  logic [SYNC_STAGES-1:0]      cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0][3:0] io_sync_q, io_sync_d;
  logic                        cs_s;
  logic [3:0]                  io_s;

  always_comb begin
    cs_sync_d = {cs_sync_q[SYNC_STAGES-2:0], cs_n};
    io_sync_d = {io_sync_q[SYNC_STAGES-2:0], io_in};
  end

  // cs_n synchronizer resets to deselected so nothing starts out of reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_sync_q <= '1;
      io_sync_q <= '0;
    end else begin
      cs_sync_q <= cs_sync_d;
      io_sync_q <= io_sync_d;
    end
  end

  assign cs_s = cs_sync_q[SYNC_STAGES-1];
  assign io_s = io_sync_q[SYNC_STAGES-1];

  logic [7:0] mem [DEPTH];

  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [6:0]        cmd_sh_q, cmd_sh_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rd_q, rd_d;
  logic [3:0]        hi_q, hi_d;
  logic              nib_q, nib_d;
  logic              oe_q, oe_d;
  logic [3:0]        out_q, out_d;
  logic              err_q, err_d;

  logic [7:0]        opcode;
  logic [7:0]        rd_byte;
  logic              mem_we;
  logic [7:0]        wbyte;

  assign opcode  = {cmd_sh_q, io_s[0]};
  assign rd_byte = mem[addr_q];
  assign wbyte   = {hi_q, io_s};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cmd_sh_d = cmd_sh_q;
    addr_d   = addr_q;
    rd_d     = rd_q;
    hi_d     = hi_q;
    nib_d    = nib_q;
    oe_d     = oe_q;
    out_d    = out_q;
    err_d    = err_q;
    mem_we   = 1'b0;

    if (cs_s) begin
      // Deselect aborts anything in flight; a half-received write byte is lost
      state_d = ST_IDLE;
      oe_d    = 1'b0;
      cnt_d   = '0;
      nib_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_CMD;
          cnt_d   = '0;
        end

        ST_CMD: begin
          if (sclk_rise) begin
            cmd_sh_d = opcode[6:0];
            if (cnt_q == 8'd7) begin
              cnt_d = '0;
              if (opcode == CMD_QREAD) begin
                state_d = ST_ADDR;
                rd_d    = 1'b1;
              end else if (opcode == CMD_QWRITE) begin
                state_d = ST_ADDR;
                rd_d    = 1'b0;
              end else begin
                state_d = ST_IGNORE;
                err_d   = 1'b1;
              end
            end else begin
              cnt_d = cnt_q + 8'd1;
            end
          end
        end

        ST_ADDR: begin
          if (sclk_rise) begin
            // Only the low ADDR_W bits survive the shift
            addr_d = ADDR_W'({addr_q, io_s});
            if (cnt_q == 8'(ADDR_NIBBLES - 1)) begin
              if (rd_q) begin
                state_d = ST_DUMMY;
                cnt_d   = 8'(DUMMY_CYCLES);
              end else begin
                state_d = ST_WDATA;
                cnt_d   = '0;
                nib_d   = 1'b0;
              end
            end else begin
              cnt_d = cnt_q + 8'd1;
            end
          end
        end

        ST_DUMMY: begin
          if (sclk_rise && cnt_q != 8'd0) begin
            cnt_d = cnt_q - 8'd1;
          end else if (sclk_fall && cnt_q == 8'd0) begin
            state_d = ST_RDATA;
            oe_d    = 1'b1;
            out_d   = rd_byte[7:4];
            nib_d   = 1'b1;
          end
        end

        ST_RDATA: begin
          if (sclk_fall) begin
            if (nib_q) begin
              out_d  = rd_byte[3:0];
              addr_d = addr_q + ADDR_W'(1);
              nib_d  = 1'b0;
            end else begin
              out_d  = rd_byte[7:4];
              nib_d  = 1'b1;
            end
          end
        end

        ST_WDATA: begin
          if (sclk_rise) begin
            if (!nib_q) begin
              hi_d  = io_s;
              nib_d = 1'b1;
            end else begin
              mem_we = 1'b1;
              addr_d = addr_q + ADDR_W'(1);
              nib_d  = 1'b0;
            end
          end
        end

        ST_IGNORE: begin
          oe_d = 1'b0;
        end

        default: begin
          state_d = ST_IDLE;
          oe_d    = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      cmd_sh_q <= '0;
      addr_q   <= '0;
      rd_q     <= 1'b0;
      hi_q     <= '0;
      nib_q    <= 1'b0;
      oe_q     <= 1'b0;
      out_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cmd_sh_q <= cmd_sh_d;
      addr_q   <= addr_d;
      rd_q     <= rd_d;
      hi_q     <= hi_d;
      nib_q    <= nib_d;
      oe_q     <= oe_d;
      out_q    <= out_d;
      err_q    <= err_d;
    end
  end

  // Backdoor has priority: a QSPI byte committing in the same cycle is dropped
  always_ff @(posedge clk) begin
    if (bd_we) begin
      mem[bd_addr] <= bd_wdata;
    end else if (mem_we) begin
      mem[addr_q] <= wbyte;
    end
  end

  assign bd_rdata = mem[bd_addr];
  assign io_out   = out_q;
  assign io_oe    = {4{oe_q}};
  assign active   = (state_q != ST_IDLE);
  assign cmd_err  = err_q;

endmodule

// File: doc/qspi_mem_responder.md
Name: qspi_mem_responder

Overview:
Synthesizable QSPI memory responder that models the external flash/PSRAM seen by the CPU's QSPI initiator. It serves quad reads (0xEB) and quad writes (0x38) from an internal byte array. It is used in the FPGA bring-up build and as a bench device in CPU-level simulations. It oversamples sclk, cs_n and io with the system clock and has a backdoor port for preloading program images.

Parameters:
ADDR_W, 8, internal memory address width; depth 2**ADDR_W bytes; the 24-bit bus address is truncated to ADDR_W LSBs.
DUMMY_CYCLES, 6, sclk rising edges between the last address nibble and the first read data nibble.
SYNC_STAGES, 2, synchronizer depth on sclk, cs_n and io_in.

Ports:
clk  in  1  system clock; must be at least 8x the sclk frequency
rst  in  1  reset, asynchronous, active-high
sclk  in  1  QSPI serial clock from initiator
cs_n  in  1  chip select, active-low
io_in  in  4  QSPI data lines from pads
io_out  out  4  QSPI data driven by responder
io_oe  out  4  output enable per line, 1 = drive
bd_we  in  1  backdoor write strobe
bd_addr  in  ADDR_W  backdoor address
bd_wdata  in  8  backdoor write data
bd_rdata  out  8  backdoor read data, combinational from bd_addr
active  out  1  high while a transaction is in progress (state != IDLE)
cmd_err  out  1  sticky flag: an unsupported opcode was received; cleared by rst only

Behaviour:
- Reset values: io_out=0, io_oe=0, active=0, cmd_err=0, state=IDLE, all counters 0. Memory contents are not reset.
- Synchronized inputs:
  - sclk, cs_n and io_in each pass through SYNC_STAGES flops.
  - A rising or falling sclk edge is detected from the last two synchronized sclk samples.
  - All protocol actions occur on the clk cycle where the edge is detected, i.e. SYNC_STAGES+1 clk after the pad edge.
- cs_n high (synchronized) forces state IDLE and io_oe=0 on the next clk, from any state.
- FSM states and transitions:
  - IDLE: waits for cs_n low, then goes to CMD with bit counter 0.
  - CMD: serial, 1 bit per rising edge on io_in[0], MSB first, 8 edges.
    - 0xEB -> ADDR with rd flag set.
    - 0x38 -> ADDR with wr flag set.
    - Any other opcode -> IGNORE and set cmd_err.
  - ADDR: quad, 6 rising edges, high nibble first, assembling 24 bits. Then 0xEB -> DUMMY, 0x38 -> WDATA.
  - DUMMY: counts DUMMY_CYCLES rising edges. On the falling edge after the last one, enter RDATA, set io_oe=4'hF and drive the high nibble of mem[addr].
  - RDATA: each subsequent falling edge drives the next nibble (low nibble, then the next byte's high nibble). After the low nibble is driven, addr increments.
  - WDATA: on rising edges the high nibble is latched and then the low nibble is latched. The byte is committed to mem[addr] on the low-nibble edge, then addr increments.
  - IGNORE: no response, io_oe=0 until cs_n rises.
- Address arithmetic: addr is ADDR_W bits and wraps from 2**ADDR_W-1 to 0 for both reads and writes.
- cs_n rises mid-byte in WDATA: the partial byte is discarded; no memory write.
- cs_n rises mid-read: io_oe drops on the next clk; no side effects.
- Backdoor:
  - bd_we writes bd_wdata into mem[bd_addr] on clk.
  - If a QSPI write commits in the same cycle, the backdoor write wins and the QSPI byte is dropped. This is a documented bench hazard.
- rst asserted mid-transaction: immediate IDLE and io_oe=0. Memory is retained.
- io_oe is either all 0s or all 1s. io_out holds its value between falling edges.

Decomposition:
- Package qspi_pkg holds:
  - opcode constants CMD_QREAD=8'hEB and CMD_QWRITE=8'h38;
  - the state typedef (IDLE, CMD, ADDR, DUMMY, RDATA, WDATA, IGNORE);
  - the ADDR_NIBBLES=6 constant.
- The package is shared with the initiator so both ends use the same opcodes.
- One sub-module, qspi_sync_edge: a SYNC_STAGES synchronizer with rise/fall detect, instantiated for sclk. Plain synchronizers are used for cs_n and io_in.

Test Plan:
- Backdoor-load mem[0x10..0x13]=A5,3C,00,FF. Issue 0xEB with addr 0x000010, 6 dummy edges, 8 data edges -> nibbles A,5,3,C,0,0,F,F; io_oe=F only during data; active=1, then 0 after cs_n rises.
- Issue 0x38 with addr 0x0000FE and data 11,22,33 -> bd_rdata at FE=11, FF=22, 00=33, confirming wrap with ADDR_W=8.
- Issue 0x38 with addr 0x20, send one full byte 0x7E plus a single nibble, then raise cs_n -> mem[0x20]=7E and mem[0x21] unchanged.
- Send opcode 0x9F -> cmd_err=1, io_oe stays 0 for the whole transaction. A following valid 0xEB still works; cmd_err remains 1.
- Assert rst during RDATA -> io_oe=0 and active=0 immediately. After release, a new 0xEB returns the same data as before the reset.
- Drive bd_we to addr 0x40 on the exact clk of a QSPI commit to 0x40 -> mem[0x40] equals the backdoor value.
